// File: rtl/servo_gate_ctrl.sv
// rtl/servo_gate_ctrl.sv - gate servo sequencing FSM with settle, hold and obstacle-reopen timing
module servo_gate_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SETTLE_MS = 500,
  parameter int unsigned HOLD_MS   = 5000
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstacle,
  input  logic       lock,
  output logic       servo_state,
  output logic [1:0] state,
  output logic       door_open,
  output logic       busy
);

  localparam logic [1:0] ST_CLOSED  = 2'b00;
  localparam logic [1:0] ST_OPENING = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;
  localparam logic [1:0] ST_CLOSING = 2'b11;

  localparam logic [9:0]  TICK_LAST   = 10'(TICK_DIV - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_MS - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_MS - 1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic        servo_q, servo_d;
  logic        door_q, door_d;
  logic        busy_q, busy_d;
  logic        tick;
  logic        expired;
  logic        restart;
  logic [15:0] last_ms;

  always_comb begin
    tick    = (presc_q == TICK_LAST);
    last_ms = (state_q == ST_OPEN) ? HOLD_LAST : SETTLE_LAST;
    expired = tick && (ms_q == last_ms);
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        if (open_req && !lock) state_d = ST_OPENING;
      end
      ST_OPENING: begin
        if (expired) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        // Obstacle or a fresh open request keeps the gate open and restarts the hold
        if (obstacle || open_req) restart = 1'b1;
        else if (close_req || expired) state_d = ST_CLOSING;
      end
      default: begin
        if (obstacle) state_d = ST_OPENING;
        else if (open_req && !lock) state_d = ST_OPENING;
        else if (expired) state_d = ST_CLOSED;
      end
    endcase
  end

  // Timer restarts from zero in the first cycle of every state and on a hold restart
  always_comb begin
    presc_d = presc_q + 10'd1;
    ms_d    = ms_q;
    if ((state_d != state_q) || restart || (state_q == ST_CLOSED)) begin
      presc_d = 10'd0;
      ms_d    = 16'd0;
    end else if (tick) begin
      presc_d = 10'd0;
      ms_d    = ms_q + 16'd1;
    end
  end

  always_comb begin
    servo_d = (state_d == ST_OPENING) || (state_d == ST_OPEN);
    door_d  = (state_d == ST_OPEN);
    busy_d  = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOSED;
      presc_q <= 10'd0;
      ms_q    <= 16'd0;
      servo_q <= 1'b0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      servo_q <= servo_d;
      door_q  <= door_d;
      busy_q  <= busy_d;
    end
  end

  assign state       = state_q;
  assign servo_state = servo_q;
  assign door_open   = door_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_servo_gate_ctrl.sv
// tb/tb_servo_gate_ctrl.sv - self-checking bench for servo_gate_ctrl against a cycle-countdown model
`timescale 1ns/1ps
module tb_servo_gate_ctrl;

  localparam int TD     = 10;
  localparam int SETTLE = 3;
  localparam int HOLD   = 5;

  logic       clk_1MHz = 1'b0;
  logic       rst_n;
  logic       open_req, close_req, obstacle, lock;
  logic       servo_state, door_open, busy;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int n;

  // Model: current state (0 closed,1 opening,2 open,3 closing) and cycles left in the interval
  int m_state;
  int m_remain;

  servo_gate_ctrl #(.TICK_DIV(TD), .SETTLE_MS(SETTLE), .HOLD_MS(HOLD)) dut (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .open_req   (open_req),
    .close_req  (close_req),
    .obstacle   (obstacle),
    .lock       (lock),
    .servo_state(servo_state),
    .state      (state),
    .door_open  (door_open),
    .busy       (busy)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic void m_enter(input int s);
    m_state = s;
    if (s == 1 || s == 3) m_remain = SETTLE * TD;
    else if (s == 2) m_remain = HOLD * TD;
    else m_remain = 0;
  endfunction

  function automatic void m_reset();
    m_enter(0);
  endfunction

  function automatic void m_step();
    bit expire;
    expire = (m_state != 0) && (m_remain == 1);
    case (m_state)
      0: if (open_req && !lock) m_enter(1);
      1: if (expire) m_enter(2); else m_remain--;
      2: begin
        if (obstacle || open_req) m_remain = HOLD * TD;
        else if (close_req || expire) m_enter(3);
        else m_remain--;
      end
      default: begin
        if (obstacle) m_enter(1);
        else if (open_req && !lock) m_enter(1);
        else if (expire) m_enter(0);
        else m_remain--;
      end
    endcase
  endfunction

  function automatic logic [31:0] m_outs();
    logic [1:0] s;
    s = 2'(m_state);
    return {27'd0, s, (m_state == 1 || m_state == 2), (m_state == 2), (m_state == 1 || m_state == 3)};
  endfunction

  task automatic step();
    @(posedge clk_1MHz);
    if (!rst_n) m_reset(); else m_step();
    cycle++;
    @(negedge clk_1MHz);
    chk("outputs", {27'd0, state, servo_state, door_open, busy}, m_outs());
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_for(input logic [1:0] s, output int cnt);
    cnt = 0;
    while (state !== s && cnt < 500) begin
      step();
      cnt++;
    end
    if (state !== s) cnt = -1;
  endtask

  task automatic pulse_open();
    open_req = 1'b1;
    step();
    open_req = 1'b0;
  endtask

  task automatic full_cycle(input string tag);
    pulse_open();
    chk({tag, "_opening"}, {30'd0, state}, 32'd1);
    chk({tag, "_servo_up"}, {31'd0, servo_state}, 32'd1);
    wait_for(2'b10, n);
    chk({tag, "_open_lat"}, n, 32'd30);
    wait_for(2'b11, n);
    chk({tag, "_hold_lat"}, n, 32'd50);
    chk({tag, "_servo_dn"}, {31'd0, servo_state}, 32'd0);
    wait_for(2'b00, n);
    chk({tag, "_close_lat"}, n, 32'd30);
  endtask

  initial begin
    rst_n = 1'b0; open_req = 1'b0; close_req = 1'b0; obstacle = 1'b0; lock = 1'b0;
    m_reset();
    steps(3);
    rst_n = 1'b1;

    // Idle after reset
    steps(200);
    chk("reset_state", {27'd0, state, servo_state, door_open, busy}, 32'd0);

    full_cycle("seq");

    // Obstacle during closing reopens
    pulse_open();
    wait_for(2'b10, n);
    chk("s3_open_lat", n, 32'd30);
    wait_for(2'b11, n);
    steps(10);
    obstacle = 1'b1;
    step();
    obstacle = 1'b0;
    chk("s3_reopen", {30'd0, state}, 32'd1);
    chk("s3_reopen_servo", {31'd0, servo_state}, 32'd1);
    wait_for(2'b10, n);
    chk("s3_reopen_lat", n, 32'd30);

    // Early close from OPEN
    close_req = 1'b1;
    step();
    close_req = 1'b0;
    chk("s5_close_req", {30'd0, state}, 32'd3);
    wait_for(2'b00, n);
    chk("s5_closed_lat", n, 32'd30);

    // Lock blocks user opening
    lock = 1'b1; open_req = 1'b1;
    steps(100);
    chk("s4_locked", {30'd0, state}, 32'd0);
    lock = 1'b0; open_req = 1'b0;

    // Obstacle held in OPEN
    pulse_open();
    wait_for(2'b10, n);
    obstacle = 1'b1;
    steps(200);
    chk("s4_obst_hold", {30'd0, state}, 32'd2);
    obstacle = 1'b0;
    wait_for(2'b11, n);
    chk("s4_obst_release", n, 32'd50);

    // Simultaneous open and close in OPEN: open wins
    lock = 1'b1;
    wait_for(2'b00, n);
    lock = 1'b0;
    pulse_open();
    wait_for(2'b10, n);
    steps(7);
    open_req = 1'b1; close_req = 1'b1;
    step();
    open_req = 1'b0; close_req = 1'b0;
    chk("s5_both", {30'd0, state}, 32'd2);
    wait_for(2'b11, n);
    chk("s5_both_lat", n, 32'd50);
    wait_for(2'b00, n);

    // Asynchronous reset mid-opening
    pulse_open();
    steps(14);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("s6_async_state", {30'd0, state}, 32'd0);
    chk("s6_async_servo", {31'd0, servo_state}, 32'd0);
    steps(3);
    rst_n = 1'b1;
    full_cycle("s6");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      open_req  = ($urandom_range(0, 39) == 0);
      close_req = ($urandom_range(0, 49) == 0);
      obstacle  = ($urandom_range(0, 59) == 0);
      lock      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        m_reset();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
